// File: rtl/dff_scan_pkg.sv
// Shared definitions for the flop-state scan-out reader: FSM encoding and the
// levels the serial link rests at between frames.
package dff_scan_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } scan_state_e;

  localparam logic IDLE_CS_N = 1'b1;
  localparam logic IDLE_SCLK = 1'b0;
  localparam logic IDLE_SDO  = 1'b0;

endpackage

// File: rtl/scan_tick_gen.sv
// Half-period divider: tick is high in the last clk cycle of each DIV-cycle
// half-period; clr holds the count at zero.
module scan_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_r;

  assign tick = (div_cnt_r == CNT_LAST);

  // Divider count, restarting at every half-period boundary or while cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DW{1'b0}};
    end else if (clr || tick) begin
      div_cnt_r <= {DW{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

endmodule

// File: rtl/dff_state_scanout.sv
// Snapshots WIDTH probed flop outputs on start and shifts them out over a
// cs_n/sclk/sdo link (mode 0: sdo changes on sclk fall, sampled on rise).
module dff_state_scanout
  import dff_scan_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] probe,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic             sdo
);

  localparam int HW = $clog2(2 * WIDTH + 1);
  localparam logic [HW-1:0] H_LAST = HW'(2 * WIDTH);

  scan_state_e      state_r, state_nxt_s;
  logic [WIDTH-1:0] shadow_r, shadow_nxt_s;
  logic [HW-1:0]    h_r, h_nxt_s, h_inc_s;
  logic             cs_n_r, cs_n_nxt_s;
  logic             sclk_r, sclk_nxt_s;
  logic             sdo_r, sdo_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             tick_s, clr_s;
  logic             first_bit_s, next_bit_s;
  logic [31:0]      k_s, idx_s;
  logic [WIDTH-1:0] shifted_s;

  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign cs_n = cs_n_r;
  assign sclk = sclk_r;
  assign sdo  = sdo_r;

  // Bit k of the frame is held from half-period 2k; idx maps k onto the shadow
  assign h_inc_s     = h_r + HW'(1);
  assign first_bit_s = MSB_FIRST ? probe[WIDTH-1] : probe[0];
  assign k_s         = 32'(h_inc_s) >> 1;
  assign idx_s       = MSB_FIRST ? (32'(WIDTH - 1) - k_s) : k_s;
  assign shifted_s   = shadow_r >> idx_s;
  assign next_bit_s  = shifted_s[0];

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_nxt_s  = state_r;
    shadow_nxt_s = shadow_r;
    h_nxt_s      = h_r;
    cs_n_nxt_s   = cs_n_r;
    sclk_nxt_s   = sclk_r;
    sdo_nxt_s    = sdo_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s      = 1'b1;
        cs_n_nxt_s = IDLE_CS_N;
        sclk_nxt_s = IDLE_SCLK;
        busy_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s  = ST_SHIFT;
          shadow_nxt_s = probe;
          cs_n_nxt_s   = 1'b0;
          busy_nxt_s   = 1'b1;
          sdo_nxt_s    = first_bit_s;
          h_nxt_s      = {HW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          if (h_r == H_LAST) begin
            state_nxt_s = ST_IDLE;
            cs_n_nxt_s  = IDLE_CS_N;
            sclk_nxt_s  = IDLE_SCLK;
            sdo_nxt_s   = IDLE_SDO;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            h_nxt_s    = h_inc_s;
            sclk_nxt_s = h_inc_s[0];
            if (h_inc_s[0]) begin
              sdo_nxt_s = sdo_r;
            end else if (h_inc_s == H_LAST) begin
              sdo_nxt_s = IDLE_SDO;
            end else begin
              sdo_nxt_s = next_bit_s;
            end
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cs_n_nxt_s  = IDLE_CS_N;
        sclk_nxt_s  = IDLE_SCLK;
        sdo_nxt_s   = IDLE_SDO;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, snapshot and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      shadow_r <= {WIDTH{1'b0}};
      h_r      <= {HW{1'b0}};
      cs_n_r   <= IDLE_CS_N;
      sclk_r   <= IDLE_SCLK;
      sdo_r    <= IDLE_SDO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shadow_r <= shadow_nxt_s;
      h_r      <= h_nxt_s;
      cs_n_r   <= cs_n_nxt_s;
      sclk_r   <= sclk_nxt_s;
      sdo_r    <= sdo_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_dff_state_scanout.sv
// Scoreboard bench for dff_state_scanout: a 16-bit/DIV=4/MSB-first instance
// and a 3-bit/DIV=1/LSB-first instance share clock and reset.
module tb_dff_state_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] probe_a = 16'h0000;
  logic        start_a = 1'b0;
  logic        busy_a, done_a, cs_n_a, sclk_a, sdo_a;
  logic [2:0]  probe_b = 3'b000;
  logic        start_b = 1'b0;
  logic        busy_b, done_b, cs_n_b, sclk_b, sdo_b;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  int frames_a = 0, frames_b = 0;
  int gap_one_a = 0;
  int stray_done = 0, busy_err = 0;

  always #5 clk = ~clk;

  dff_state_scanout #(.WIDTH(16), .DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .probe(probe_a), .start(start_a),
    .busy(busy_a), .done(done_a), .cs_n(cs_n_a), .sclk(sclk_a), .sdo(sdo_a)
  );

  dff_state_scanout #(.WIDTH(3), .DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .probe(probe_b), .start(start_b),
    .busy(busy_b), .done(done_b), .cs_n(cs_n_b), .sclk(sclk_b), .sdo(sdo_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Monitor for instance A: collects bits on sclk rises, checks each frame at cs_n rise
  logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b0, in_a = 1'b0;
  int          low_a = 0, rises_a = 0, hi_a = 0;
  logic [15:0] col_a = 16'h0000;
  logic [15:0] e_a;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        in_a = 1'b0; prev_cs_a = 1'b1; prev_sclk_a = 1'b0; hi_a = 0;
        if (done_a) stray_done++;
      end else begin
        if (busy_a !== ~cs_n_a) busy_err++;
        if (cs_n_a == 1'b0) begin
          if (prev_cs_a) begin
            in_a = 1'b1; low_a = 0; rises_a = 0; col_a = 16'h0000;
            if (hi_a == 1) gap_one_a++;
          end
          low_a++;
          if (sclk_a && !prev_sclk_a) begin
            rises_a++;
            col_a = {col_a[14:0], sdo_a};
          end
        end else begin
          if (!prev_cs_a && in_a) begin
            if (exp_a.size() == 0) begin
              chk("a_unexpected_frame", 32'(col_a), 32'hFFFF_FFFF);
            end else begin
              e_a = exp_a.pop_front();
              chk("a_bits", 32'(col_a), 32'(e_a));
            end
            chk("a_cs_low_len", 32'(low_a), 32'd132);
            chk("a_sclk_rises", 32'(rises_a), 32'd16);
            chk("a_done_pulse", 32'(done_a), 32'd1);
            chk("a_sdo_idle", 32'(sdo_a), 32'd0);
            frames_a++; in_a = 1'b0; hi_a = 0;
          end else if (done_a) begin
            stray_done++;
          end
          hi_a++;
        end
        prev_cs_a = cs_n_a; prev_sclk_a = sclk_a;
      end
    end
  end

  // Monitor for instance B
  logic        prev_cs_b = 1'b1, prev_sclk_b = 1'b0, in_b = 1'b0;
  int          low_b = 0, rises_b = 0;
  logic [15:0] col_b = 16'h0000;
  logic [15:0] e_b;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        in_b = 1'b0; prev_cs_b = 1'b1; prev_sclk_b = 1'b0;
        if (done_b) stray_done++;
      end else begin
        if (busy_b !== ~cs_n_b) busy_err++;
        if (cs_n_b == 1'b0) begin
          if (prev_cs_b) begin
            in_b = 1'b1; low_b = 0; rises_b = 0; col_b = 16'h0000;
          end
          low_b++;
          if (sclk_b && !prev_sclk_b) begin
            rises_b++;
            col_b = {col_b[14:0], sdo_b};
          end
        end else begin
          if (!prev_cs_b && in_b) begin
            if (exp_b.size() == 0) begin
              chk("b_unexpected_frame", 32'(col_b), 32'hFFFF_FFFF);
            end else begin
              e_b = exp_b.pop_front();
              chk("b_bits", 32'(col_b), 32'(e_b));
            end
            chk("b_cs_low_len", 32'(low_b), 32'd7);
            chk("b_sclk_rises", 32'(rises_b), 32'd3);
            chk("b_done_pulse", 32'(done_b), 32'd1);
            frames_b++; in_b = 1'b0;
          end else if (done_b) begin
            stray_done++;
          end
        end
        prev_cs_b = cs_n_b; prev_sclk_b = sclk_b;
      end
    end
  end

  task automatic wait_frames_a(input int target);
    int cyc = 0;
    while (frames_a < target && cyc < 600) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (frames_a < target) chk("a_frame_timeout", 32'(frames_a), 32'(target));
  endtask

  task automatic wait_frames_b(input int target);
    int cyc = 0;
    while (frames_b < target && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (frames_b < target) chk("b_frame_timeout", 32'(frames_b), 32'(target));
  endtask

  task automatic pulse_start_a(input logic [15:0] val, input bit expect_frame);
    @(posedge clk); #1;
    probe_a = val; start_a = 1'b1;
    if (expect_frame) exp_a.push_back(val);
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_cs_n"}, 32'(cs_n_a), 32'd1);
    chk({tag, "_sclk"}, 32'(sclk_a), 32'd0);
    chk({tag, "_sdo"},  32'(sdo_a),  32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    int base;
    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_a("por_a");
    chk("por_b_cs_n", 32'(cs_n_b), 32'd1);
    chk("por_b_busy", 32'(busy_b), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    repeat (4) @(posedge clk);

    // Basic frame, MSB first
    pulse_start_a(16'hA5C3, 1'b1);
    wait_frames_a(1);
    repeat (5) @(posedge clk);

    // Probe changes after capture must not disturb the frame
    pulse_start_a(16'hA5C3, 1'b1);
    probe_a = 16'hFFFF;
    wait_frames_a(2);
    repeat (5) @(posedge clk);

    // Reset mid-frame aborts without a done pulse
    pulse_start_a(16'h3C5A, 1'b0);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_a("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (150) @(posedge clk);
    @(negedge clk);
    chk("rst_no_frame", 32'(frames_a), 32'd2);
    check_idle_a("post_rst");
    repeat (3) @(posedge clk);

    // start held high: three back-to-back frames, 1-cycle gaps
    base = frames_a;
    @(posedge clk); #1;
    probe_a = 16'h1234; start_a = 1'b1;
    repeat (3) exp_a.push_back(16'h1234);
    wait_frames_a(base + 3);
    start_a = 1'b0;
    repeat (150) @(posedge clk);
    chk("held_frames", 32'(frames_a), 32'(base + 3));
    chk("held_gap_one", 32'(gap_one_a), 32'd2);

    // start pulses during SHIFT are ignored
    base = frames_a;
    pulse_start_a(16'h0F0F, 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (25) @(posedge clk);
      #1 probe_a = 16'hDEAD; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
    end
    wait_frames_a(base + 1);
    repeat (150) @(posedge clk);
    chk("ignore_frames", 32'(frames_a), 32'(base + 1));

    // DIV=1, LSB-first, WIDTH=3
    @(posedge clk); #1;
    probe_b = 3'b110; start_b = 1'b1;
    exp_b.push_back(16'(rev3(3'b110)));
    @(posedge clk); #1 start_b = 1'b0;
    wait_frames_b(1);
    repeat (3) @(posedge clk); #1;
    probe_b = 3'b001; start_b = 1'b1;
    exp_b.push_back(16'(rev3(3'b001)));
    @(posedge clk); #1 start_b = 1'b0;
    wait_frames_b(2);
    repeat (5) @(posedge clk);

    @(negedge clk);
    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    chk("stray_done", 32'(stray_done), 32'd0);
    chk("busy_vs_cs", 32'(busy_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
